// File: rtl/bus_pkg.sv
// Shared types and constants for the STB/WE/ACK bus initiator.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } busState_t;

    localparam int ADDR_STRIDE = 4;
    localparam int MAX_BURST   = 16;

endpackage

// File: rtl/bus_ack_timer.sv
// Loadable down-counter watching how long a strobe waits for an acknowledge.
module bus_ack_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] loadVal,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Expires in the last allowed cycle so the strobe lasts exactly loadVal cycles.
    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/bus_rd_master.sv
// Single-command bus initiator: one write or a 1..16 word read burst per command.
// Define BUS_RD_MASTER_TIMEOUT_EN to compile in the acknowledge watchdog.
module bus_rd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCMD_VLD,
    output logic              oCMD_RDY,
    input  logic              iCMD_WE,
    input  logic [ADDR_W-1:0] iCMD_ADR,
    input  logic [3:0]        iCMD_LEN,
    input  logic [DATA_W-1:0] iCMD_WDAT,
    output logic [ADDR_W-1:0] oADR,
    output logic [DATA_W-1:0] oDAT,
    input  logic [DATA_W-1:0] iDAT,
    output logic              oSTB,
    output logic              oWE,
    input  logic              iACK,
    output logic              oRD_VLD,
    output logic [DATA_W-1:0] oRD_DAT,
    input  logic              iRD_RDY,
    output logic              oDONE,
    output logic              oERR
);
    import bus_pkg::*;

    busState_t         state, stateNext;
    logic [ADDR_W-1:0] baseAdr;
    logic [ADDR_W-1:0] beatAdr;
    logic [3:0]        lenReg;
    logic [3:0]        idx;
    logic              weReg;
    logic [DATA_W-1:0] wdatReg;
    logic [DATA_W-1:0] rdDatReg;
    logic              accept;
    logic              ackExpired;

    assign accept  = (state == IDLE) && iCMD_VLD;
    assign beatAdr = baseAdr + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (iCMD_VLD) stateNext = REQ;
            // An acknowledge in the expiry cycle still completes the beat normally.
            REQ: begin
                if (iACK) begin
                    stateNext = weReg ? DONE : OUT;
                end else if (ackExpired) begin
                    stateNext = DONE;
                end
            end
            OUT:  if (iRD_RDY) stateNext = (idx == lenReg) ? DONE : REQ;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            baseAdr  <= '0;
            lenReg   <= '0;
            idx      <= '0;
            weReg    <= 1'b0;
            wdatReg  <= '0;
            rdDatReg <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                baseAdr <= iCMD_ADR;
                lenReg  <= iCMD_LEN;
                weReg   <= iCMD_WE;
                wdatReg <= iCMD_WDAT;
                idx     <= '0;
            end
            if ((state == REQ) && iACK && !weReg) begin
                rdDatReg <= iDAT;
            end
            if ((state == OUT) && iRD_RDY && (idx != lenReg)) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef BUS_RD_MASTER_TIMEOUT_EN
    logic errReg;

    bus_ack_timer #(
        .CNT_W(8)
    ) uAckTimer (
        .clk    (iCLK),
        .rst    (iRST),
        .load   (state != REQ),
        .loadVal(8'(TIMEOUT)),
        .dec    (state == REQ),
        .expired(ackExpired)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            errReg <= 1'b0;
        end else begin
            errReg <= (state == REQ) && !iACK && ackExpired;
        end
    end

    assign oERR = (state == DONE) && errReg;
`else
    logic unusedTimeout;

    assign unusedTimeout = |8'(TIMEOUT);
    assign ackExpired    = 1'b0;
    assign oERR          = 1'b0;
`endif

    assign oCMD_RDY = (state == IDLE);
    assign oSTB     = (state == REQ);
    assign oWE      = (state == REQ) && weReg;
    assign oADR     = (state == REQ) ? beatAdr : '0;
    assign oDAT     = ((state == REQ) && weReg) ? wdatReg : '0;
    assign oRD_VLD  = (state == OUT);
    assign oRD_DAT  = rdDatReg;
    assign oDONE    = (state == DONE);

endmodule

// File: tb/tb_bus_rd_master.sv
// Randomized self-checking bench for bus_rd_master with a behavioural slave and stream sink.
module tb_bus_rd_master;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        iRST = 1'b1;
    logic        iCMD_VLD = 1'b0;
    logic        oCMD_RDY;
    logic        iCMD_WE = 1'b0;
    logic [31:0] iCMD_ADR = '0;
    logic [3:0]  iCMD_LEN = '0;
    logic [31:0] iCMD_WDAT = '0;
    logic [31:0] oADR;
    logic [31:0] oDAT;
    logic [31:0] iDAT = '0;
    logic        oSTB;
    logic        oWE;
    logic        iACK = 1'b0;
    logic        oRD_VLD;
    logic [31:0] oRD_DAT;
    logic        iRD_RDY = 1'b0;
    logic        oDONE;
    logic        oERR;

    int checks = 0;
    int errors = 0;

    bus_rd_master #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .iCLK     (clk),
        .iRST     (iRST),
        .iCMD_VLD (iCMD_VLD),
        .oCMD_RDY (oCMD_RDY),
        .iCMD_WE  (iCMD_WE),
        .iCMD_ADR (iCMD_ADR),
        .iCMD_LEN (iCMD_LEN),
        .iCMD_WDAT(iCMD_WDAT),
        .oADR     (oADR),
        .oDAT     (oDAT),
        .iDAT     (iDAT),
        .oSTB     (oSTB),
        .oWE      (oWE),
        .iACK     (iACK),
        .oRD_VLD  (oRD_VLD),
        .oRD_DAT  (oRD_DAT),
        .iRD_RDY  (iRD_RDY),
        .oDONE    (oDONE),
        .oERR     (oERR)
    );

    always #5 clk = ~clk;

    // Slave contents: three constant registers, everything else a pattern of the address.
    function automatic logic [31:0] slaveData(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0123_4567;
            32'h4:   return 32'h89AB_CDEF;
            32'h8:   return 32'hFEDC_BA98;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Environment knobs and observation logs
    int          ackEn = 1;
    int          ackDelayMode = 0;
    int          rdyProb = 100;
    int          holdBeat = -1;
    int          holdCnt = 0;
    int          cyc = 0;
    int          doneCnt = 0;
    logic        lastErr = 1'b0;
    int          doneCyc = 0;
    int          ackCyc = 0;
    int          beats = 0;
    int          wrBeats = 0;
    logic [31:0] wrDat = '0;
    int          stbCyc = 0;
    int          rdVldSeen = 0;
    int          overlapErr = 0;
    int          stableErr = 0;
    int          wordCnt = 0;
    int          curDelay = 0;
    int          waitCnt = 0;
    logic        prevStb = 1'b0;
    logic        vldPending = 1'b0;
    logic [31:0] heldDat = '0;
    logic [31:0] adrQ[$];
    logic [31:0] datQ[$];

    always @(negedge clk) begin
        cyc++;
        if (oSTB && !prevStb) begin
            adrQ.push_back(oADR);
            beats++;
            if (oWE) begin
                wrBeats++;
                wrDat = oDAT;
            end
            curDelay = (ackDelayMode < 0) ? int'($urandom_range(0, 3)) : ackDelayMode;
            waitCnt  = 0;
        end
        if (oSTB) stbCyc++;
        if (oSTB && oRD_VLD) overlapErr++;
        if (oSTB && (ackEn != 0) && (waitCnt == curDelay)) begin
            iACK   = 1'b1;
            iDAT   = slaveData(oADR);
            ackCyc = cyc;
        end else begin
            iACK = 1'b0;
            iDAT = $urandom;
            if (oSTB) waitCnt++;
        end
        if (oRD_VLD) begin
            rdVldSeen++;
            if (vldPending && (oRD_DAT !== heldDat)) stableErr++;
            heldDat = oRD_DAT;
            if ((holdBeat == wordCnt) && (holdCnt < 5)) begin
                iRD_RDY = 1'b0;
                holdCnt++;
            end else begin
                iRD_RDY = (int'($urandom_range(0, 99)) < rdyProb);
            end
            if (iRD_RDY) begin
                datQ.push_back(oRD_DAT);
                wordCnt++;
                vldPending = 1'b0;
            end else begin
                vldPending = 1'b1;
            end
        end else begin
            iRD_RDY    = 1'($urandom_range(0, 1));
            vldPending = 1'b0;
        end
        if (oDONE) begin
            doneCnt++;
            lastErr = oERR;
            doneCyc = cyc;
        end
        prevStb = oSTB;
    end

    task automatic clear_logs();
        doneCnt = 0; beats = 0; wrBeats = 0; stbCyc = 0; rdVldSeen = 0;
        overlapErr = 0; stableErr = 0; wordCnt = 0; holdCnt = 0; lastErr = 1'b0;
        adrQ.delete();
        datQ.delete();
    endtask

    task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [3:0] len,
                             input logic [31:0] wdat);
        int n = 0;
        while (!oCMD_RDY && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (!oCMD_RDY) begin
            errors++;
            $display("FAIL cmd_rdy_wait: oCMD_RDY=%0b required 1", oCMD_RDY);
        end
        iCMD_WE = we; iCMD_ADR = adr; iCMD_LEN = len; iCMD_WDAT = wdat; iCMD_VLD = 1'b1;
        @(posedge clk); #2;
        iCMD_VLD = 1'b0;
        iCMD_WE = 1'($urandom); iCMD_ADR = $urandom; iCMD_LEN = 4'($urandom); iCMD_WDAT = $urandom;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (doneCnt == 0 && n < 3000) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (doneCnt == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: no oDONE within %0d cycles", name, n);
        end
        checks++;
        if (oCMD_RDY !== 1'b1) begin
            errors++;
            $display("FAIL %s_rdy_after_done: oCMD_RDY=%b required 1", name, oCMD_RDY);
        end
    endtask

    // Reference: a read of len+1 words visits base+4*i (mod 2^32) and returns the slave words in order.
    task automatic check_read(input string name, input logic [31:0] adr, input int len,
                              input logic expErr);
        logic [31:0] a;
        checks++;
        if (datQ.size() != len + 1 || adrQ.size() != len + 1) begin
            errors++;
            $display("FAIL %s_count: words=%0d beats=%0d required %0d", name, datQ.size(),
                     adrQ.size(), len + 1);
        end
        for (int i = 0; i <= len; i++) begin
            a = adr + 32'(4 * i);
            if (i < adrQ.size()) begin
                checks++;
                if (adrQ[i] !== a) begin
                    errors++;
                    $display("FAIL %s_adr[%0d]: got %h required %h", name, i, adrQ[i], a);
                end
            end
            if (i < datQ.size()) begin
                checks++;
                if (datQ[i] !== slaveData(a)) begin
                    errors++;
                    $display("FAIL %s_dat[%0d]: got %h required %h", name, i, datQ[i], slaveData(a));
                end
            end
        end
        checks++;
        if (doneCnt != 1 || lastErr !== expErr) begin
            errors++;
            $display("FAIL %s_done: count=%0d err=%b required 1/%b", name, doneCnt, lastErr, expErr);
        end
        checks++;
        if (overlapErr != 0 || wrBeats != 0) begin
            errors++;
            $display("FAIL %s_bus: overlap=%0d writes=%0d required 0/0", name, overlapErr, wrBeats);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({oSTB, oWE, oRD_VLD, oDONE, oERR} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: stb/we/vld/done/err=%b required 00000",
                     {oSTB, oWE, oRD_VLD, oDONE, oERR});
        end
        checks++;
        if (oADR !== 32'h0 || oDAT !== 32'h0 || oRD_DAT !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: adr=%h dat=%h rd=%h required 0", oADR, oDAT, oRD_DAT);
        end
        checks++;
        if (oCMD_RDY !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got %b required 1", oCMD_RDY);
        end
        iRST = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_read_burst();
        ackEn = 1; ackDelayMode = 0; rdyProb = 100; holdBeat = -1;
        clear_logs();
        issue_cmd(1'b0, 32'h0, 4'd2, 32'h0);
        wait_done("burst");
        check_read("burst", 32'h0, 2, 1'b0);
        checks++;
        if (beats != 3 || stbCyc != 3) begin
            errors++;
            $display("FAIL burst_stb_gaps: rises=%0d stbcycles=%0d required 3/3", beats, stbCyc);
        end
    endtask

    task automatic test_write();
        ackEn = 1; ackDelayMode = 0; rdyProb = 100; holdBeat = -1;
        clear_logs();
        issue_cmd(1'b1, 32'h4, 4'($urandom), 32'hDEAD_BEEF);
        wait_done("write");
        checks++;
        if (wrBeats != 1 || stbCyc != 1 || wrDat !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_bus: wrbeats=%0d stb=%0d dat=%h required 1/1/deadbeef",
                     wrBeats, stbCyc, wrDat);
        end
        checks++;
        if (adrQ.size() != 1 || adrQ[0] !== 32'h4) begin
            errors++;
            $display("FAIL write_adr: beats=%0d required one at 00000004", adrQ.size());
        end
        checks++;
        if (doneCyc != ackCyc + 1 || doneCnt != 1 || lastErr !== 1'b0) begin
            errors++;
            $display("FAIL write_done: donecyc=%0d ackcyc=%0d count=%0d err=%b required ack+1/1/0",
                     doneCyc, ackCyc, doneCnt, lastErr);
        end
        checks++;
        if (rdVldSeen != 0) begin
            errors++;
            $display("FAIL write_rdvld: seen %0d cycles required 0", rdVldSeen);
        end
    endtask

    task automatic test_backpressure();
        ackEn = 1; ackDelayMode = 0; rdyProb = 100; holdBeat = 1;
        clear_logs();
        issue_cmd(1'b0, 32'h0, 4'd2, 32'h0);
        wait_done("bp");
        check_read("bp", 32'h0, 2, 1'b0);
        checks++;
        if (holdCnt != 5 || stableErr != 0 || heldDat !== 32'hFEDC_BA98) begin
            errors++;
            $display("FAIL bp_hold: held=%0d unstable=%0d last=%h required 5/0/fedcba98",
                     holdCnt, stableErr, heldDat);
        end
        holdBeat = -1;
    endtask

    task automatic test_wrap();
        ackEn = 1; ackDelayMode = 0; rdyProb = 100; holdBeat = -1;
        clear_logs();
        issue_cmd(1'b0, 32'hFFFF_FFFC, 4'd1, 32'h0);
        wait_done("wrap");
        check_read("wrap", 32'hFFFF_FFFC, 1, 1'b0);
    endtask

    task automatic test_random();
        logic        we;
        logic [31:0] adr;
        logic [3:0]  len;
        logic [31:0] wd;
        ackEn = 1; ackDelayMode = -1; rdyProb = 60; holdBeat = -1;
        for (int k = 0; k < 24; k++) begin
            clear_logs();
            we  = ($urandom_range(0, 99) < 30);
            adr = (k % 4 == 3) ? (32'hFFFF_FFC0 | {26'h0, 4'($urandom), 2'b00}) : {$urandom, 2'b00};
            len = 4'($urandom);
            wd  = $urandom;
            issue_cmd(we, adr, len, wd);
            wait_done("rand");
            if (we) begin
                checks++;
                if (wrBeats != 1 || wrDat !== wd || adrQ.size() != 1 || rdVldSeen != 0 ||
                    lastErr !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_write[%0d]: wrbeats=%0d dat=%h required 1/%h", k,
                             wrBeats, wrDat, wd);
                end else if (adrQ[0] !== adr) begin
                    errors++;
                    $display("FAIL rand_write_adr[%0d]: got %h required %h", k, adrQ[0], adr);
                end
            end else begin
                check_read("rand", adr, int'(len), 1'b0);
            end
        end
    endtask

`ifdef BUS_RD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        ackEn = 0; rdyProb = 100; holdBeat = -1;
        clear_logs();
        issue_cmd(1'b0, 32'h8, 4'd3, 32'h0);
        wait_done("tmo");
        checks++;
        if (stbCyc != TMO || beats != 1 || lastErr !== 1'b1 || doneCnt != 1 || datQ.size() != 0) begin
            errors++;
            $display("FAIL tmo_abort: stb=%0d beats=%0d err=%b done=%0d words=%0d required %0d/1/1/1/0",
                     stbCyc, beats, lastErr, doneCnt, datQ.size(), TMO);
        end
        ackEn = 1; ackDelayMode = TMO - 1;
        clear_logs();
        issue_cmd(1'b0, 32'h4, 4'd0, 32'h0);
        wait_done("tmo_edge");
        check_read("tmo_edge", 32'h4, 0, 1'b0);
        checks++;
        if (stbCyc != TMO) begin
            errors++;
            $display("FAIL tmo_edge_stb: got %0d required %0d", stbCyc, TMO);
        end
        ackDelayMode = 0;
    endtask
`endif

    task automatic test_reset_mid_burst();
        int n = 0;
        ackEn = 1; ackDelayMode = 3; rdyProb = 100; holdBeat = -1;
        clear_logs();
        issue_cmd(1'b0, 32'h100, 4'd3, 32'h0);
        while (!(oSTB && adrQ.size() == 3) && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (!(oSTB && adrQ.size() == 3)) begin
            errors++;
            $display("FAIL rstmid_reach_beat2: stb=%b beats=%0d required 1/3", oSTB, adrQ.size());
        end
        iRST = 1'b1;
        @(posedge clk); #2;
        iRST = 1'b0;
        checks++;
        if ({oSTB, oRD_VLD, oDONE, oCMD_RDY} !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_outputs: stb/vld/done/rdy=%b required 0001",
                     {oSTB, oRD_VLD, oDONE, oCMD_RDY});
        end
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (doneCnt != 0 || oSTB !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: done=%0d stb=%b required 0/0", doneCnt, oSTB);
        end
        ackDelayMode = 0;
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write();
        test_backpressure();
        test_wrap();
`ifdef BUS_RD_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_reset_mid_burst();
        test_read_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
